// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped instruction cache, 16-byte lines, register storage
// Optional feature macro: ICACHE_PERF_CNT_EN (adds hit_cnt / miss_cnt saturating counters)
module icache_dm #(
   parameter int LINE_NUM = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_sram_req,
   input  logic [31:0] inst_sram_addr,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   output logic        icache_rd_req,
   output logic [2:0]  icache_rd_type,
   output logic [31:0] icache_rd_addr,
   input  logic        icache_rd_rdy,
   input  logic        icache_ret_valid,
   input  logic        icache_ret_last,
   input  logic [31:0] icache_ret_data
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);

   localparam int IDX_W = $clog2(LINE_NUM);
   localparam int TAG_W = 28 - IDX_W;

   localparam logic [3:0] S_IDLE   = 4'b0001;
   localparam logic [3:0] S_LOOKUP = 4'b0010;
   localparam logic [3:0] S_MISS   = 4'b0100;
   localparam logic [3:0] S_REFILL = 4'b1000;

   logic [3:0]       state;
   logic [31:2]      addr_q;
   logic [31:0]      rd_addr_q;
   logic [1:0]       beat_cnt;
   logic [LINE_NUM-1:0] valid;
   logic [TAG_W-1:0] tag_arr [LINE_NUM];
   logic [31:0]      data_arr [LINE_NUM][4];

   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic [1:0]       word;
   logic             in_lookup;
   logic             hit;
   logic             unused_addr_bits;

   // Byte offset within a word never matters for instruction fetch.
   assign unused_addr_bits = ^inst_sram_addr[1:0];

   // Address decode always works on the latched fetch address.
   assign idx  = addr_q[4 +: IDX_W];
   assign tag  = addr_q[31 -: TAG_W];
   assign word = addr_q[3:2];

   assign in_lookup = (state == S_LOOKUP);
   assign hit       = in_lookup && valid[idx] && (tag_arr[idx] == tag);

   // A new fetch is accepted when idle or when the current lookup completes with a hit.
   assign inst_sram_addr_ok = inst_sram_req && ((state == S_IDLE) || hit);
   assign inst_sram_data_ok = hit;
   assign inst_sram_rdata   = hit ? data_arr[idx][word] : 32'd0;

   assign icache_rd_req  = (state == S_MISS);
   assign icache_rd_type = 3'b100;
   assign icache_rd_addr = rd_addr_q;

   // Control FSM, latched address, refill beat counter and line valid bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         addr_q    <= '0;
         rd_addr_q <= '0;
         beat_cnt  <= 2'd0;
         valid     <= '0;
      end else begin
         if (inst_sram_addr_ok) begin
            addr_q <= inst_sram_addr[31:2];
         end
         case (state)
            S_IDLE: begin
               if (inst_sram_addr_ok) begin
                  state <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (hit) begin
                  state <= inst_sram_addr_ok ? S_LOOKUP : S_IDLE;
               end else begin
                  state     <= S_MISS;
                  rd_addr_q <= {addr_q[31:4], 4'b0000};
               end
            end
            S_MISS: begin
               if (icache_rd_rdy) begin
                  state    <= S_REFILL;
                  beat_cnt <= 2'd0;
               end
            end
            S_REFILL: begin
               if (icache_ret_valid) begin
                  beat_cnt <= beat_cnt + 2'd1;
                  if (icache_ret_last) begin
                     valid[idx] <= 1'b1;
                     state      <= S_LOOKUP;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Line payload and tag storage; only meaningful once the valid bit is set.
   always_ff @(posedge clk) begin
      if (!reset && (state == S_REFILL) && icache_ret_valid) begin
         data_arr[idx][beat_cnt] <= icache_ret_data;
         if (icache_ret_last) begin
            tag_arr[idx] <= tag;
         end
      end
   end

`ifdef ICACHE_PERF_CNT_EN
   // Saturating counters of lookup outcomes.
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_cnt  <= 32'd0;
         miss_cnt <= 32'd0;
      end else begin
         if (hit && (hit_cnt != 32'hFFFF_FFFF)) begin
            hit_cnt <= hit_cnt + 32'd1;
         end
         if (in_lookup && !hit && (miss_cnt != 32'hFFFF_FFFF)) begin
            miss_cnt <= miss_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - directed self-checking bench for icache_dm
module tb_icache_dm;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_sram_req;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic        icache_rd_req;
   logic [2:0]  icache_rd_type;
   logic [31:0] icache_rd_addr;
   logic        icache_rd_rdy;
   logic        icache_ret_valid;
   logic        icache_ret_last;
   logic [31:0] icache_ret_data;
`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   int tests = 0;
   int fails = 0;

   icache_dm #(.LINE_NUM(8)) dut (
      .clk              (clk),
      .reset            (reset),
      .inst_sram_req    (inst_sram_req),
      .inst_sram_addr   (inst_sram_addr),
      .inst_sram_addr_ok(inst_sram_addr_ok),
      .inst_sram_data_ok(inst_sram_data_ok),
      .inst_sram_rdata  (inst_sram_rdata),
      .icache_rd_req    (icache_rd_req),
      .icache_rd_type   (icache_rd_type),
      .icache_rd_addr   (icache_rd_addr),
      .icache_rd_rdy    (icache_rd_rdy),
      .icache_ret_valid (icache_ret_valid),
      .icache_ret_last  (icache_ret_last),
      .icache_ret_data  (icache_ret_data)
`ifdef ICACHE_PERF_CNT_EN
      ,
      .hit_cnt          (hit_cnt),
      .miss_cnt         (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      inst_sram_req = 1'b0;
      inst_sram_addr = 32'd0;
      icache_rd_rdy = 1'b0;
      icache_ret_valid = 1'b0;
      icache_ret_last = 1'b0;
      icache_ret_data = 32'd0;
      step();
      step();
      reset = 1'b0;
      #2;
      tests++; if (inst_sram_addr_ok !== 1'b0) begin fails++; $display("FAIL reset_addr_ok got %b want 0", inst_sram_addr_ok); end
      tests++; if (inst_sram_data_ok !== 1'b0) begin fails++; $display("FAIL reset_data_ok got %b want 0", inst_sram_data_ok); end
      tests++; if (inst_sram_rdata !== 32'd0) begin fails++; $display("FAIL reset_rdata got %h want 0", inst_sram_rdata); end
      tests++; if (icache_rd_req !== 1'b0) begin fails++; $display("FAIL reset_rd_req got %b want 0", icache_rd_req); end
      tests++; if (icache_rd_type !== 3'b100) begin fails++; $display("FAIL reset_rd_type got %b want 100", icache_rd_type); end
      tests++; if (icache_rd_addr !== 32'd0) begin fails++; $display("FAIL reset_rd_addr got %h want 0", icache_rd_addr); end
`ifdef ICACHE_PERF_CNT_EN
      tests++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin fails++; $display("FAIL reset_cnt got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
`endif
   endtask

   task automatic test_cold_miss;
      inst_sram_req = 1'b1;
      inst_sram_addr = 32'h1C00_0008;
      #2;
      tests++; if (inst_sram_addr_ok !== 1'b1) begin fails++; $display("FAIL cold_addr_ok got %b want 1", inst_sram_addr_ok); end
      step();
      inst_sram_req = 1'b0;
      #2;
      tests++; if (inst_sram_data_ok !== 1'b0) begin fails++; $display("FAIL cold_lookup_data_ok got %b want 0", inst_sram_data_ok); end
      step();
      icache_rd_rdy = 1'b1;
      #2;
      tests++; if (icache_rd_req !== 1'b1) begin fails++; $display("FAIL cold_rd_req got %b want 1", icache_rd_req); end
      tests++; if (icache_rd_addr !== 32'h1C00_0000) begin fails++; $display("FAIL cold_rd_addr got %h want 1c000000", icache_rd_addr); end
      tests++; if (icache_rd_type !== 3'b100) begin fails++; $display("FAIL cold_rd_type got %b want 100", icache_rd_type); end
      step();
      icache_rd_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         icache_ret_valid = 1'b1;
         icache_ret_data = 32'h11 * (i + 1);
         icache_ret_last = (i == 3);
         #2;
         tests++; if (icache_rd_req !== 1'b0 || inst_sram_data_ok !== 1'b0) begin fails++; $display("FAIL cold_refill_beat%0d rd_req/data_ok got %b%b want 00", i, icache_rd_req, inst_sram_data_ok); end
         step();
      end
      icache_ret_valid = 1'b0;
      icache_ret_last = 1'b0;
      #2;
      tests++; if (inst_sram_data_ok !== 1'b1) begin fails++; $display("FAIL cold_data_ok got %b want 1", inst_sram_data_ok); end
      tests++; if (inst_sram_rdata !== 32'h33) begin fails++; $display("FAIL cold_rdata got %h want 33", inst_sram_rdata); end
      step();
   endtask

   task automatic test_hit_stream;
      logic [31:0] addrs [3];
      logic [31:0] exp   [3];
      addrs[0] = 32'h1C00_0000; addrs[1] = 32'h1C00_0004; addrs[2] = 32'h1C00_000C;
      exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h44;
      for (int k = 0; k < 4; k++) begin
         inst_sram_req = (k < 3);
         inst_sram_addr = (k < 3) ? addrs[k] : 32'd0;
         #2;
         tests++; if (inst_sram_addr_ok !== (k < 3)) begin fails++; $display("FAIL hit_addr_ok%0d got %b want %b", k, inst_sram_addr_ok, (k < 3)); end
         tests++; if (icache_rd_req !== 1'b0) begin fails++; $display("FAIL hit_rd_req%0d got %b want 0", k, icache_rd_req); end
         if (k == 0) begin
            tests++; if (inst_sram_data_ok !== 1'b0) begin fails++; $display("FAIL hit_data_ok0 got %b want 0", inst_sram_data_ok); end
         end else begin
            tests++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== exp[k-1]) begin fails++; $display("FAIL hit_data%0d got ok=%b %h want ok=1 %h", k, inst_sram_data_ok, inst_sram_rdata, exp[k-1]); end
         end
         step();
      end
`ifdef ICACHE_PERF_CNT_EN
      tests++; if (hit_cnt !== 32'd4) begin fails++; $display("FAIL perf_hit_cnt got %0d want 4", hit_cnt); end
      tests++; if (miss_cnt !== 32'd1) begin fails++; $display("FAIL perf_miss_cnt got %0d want 1", miss_cnt); end
`endif
   endtask

   task automatic test_conflict_stall;
      inst_sram_req = 1'b1;
      inst_sram_addr = 32'h1C00_0080;
      #2;
      tests++; if (inst_sram_addr_ok !== 1'b1) begin fails++; $display("FAIL conf_addr_ok got %b want 1", inst_sram_addr_ok); end
      step();
      inst_sram_req = 1'b0;
      #2;
      tests++; if (inst_sram_data_ok !== 1'b0) begin fails++; $display("FAIL conf_miss got data_ok %b want 0", inst_sram_data_ok); end
      step();
      icache_rd_rdy = 1'b1;
      #2;
      tests++; if (icache_rd_req !== 1'b1 || icache_rd_addr !== 32'h1C00_0080) begin fails++; $display("FAIL conf_rd got %b %h want 1 1c000080", icache_rd_req, icache_rd_addr); end
      step();
      icache_rd_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         icache_ret_valid = 1'b1;
         icache_ret_data = 32'hA0 + i;
         icache_ret_last = (i == 3);
         step();
      end
      icache_ret_valid = 1'b0;
      icache_ret_last = 1'b0;
      #2;
      tests++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'hA0) begin fails++; $display("FAIL conf_data got ok=%b %h want ok=1 a0", inst_sram_data_ok, inst_sram_rdata); end
      step();
      inst_sram_req = 1'b1;
      inst_sram_addr = 32'h1C00_0000;
      step();
      inst_sram_req = 1'b0;
      #2;
      tests++; if (inst_sram_data_ok !== 1'b0) begin fails++; $display("FAIL conf_evicted got data_ok %b want 0", inst_sram_data_ok); end
      step();
      inst_sram_req = 1'b1;
      inst_sram_addr = 32'h1C00_0004;
      icache_ret_valid = 1'b1;
      icache_ret_data = 32'hDEAD_BEEF;
      for (int c = 0; c < 10; c++) begin
         #2;
         tests++; if (icache_rd_req !== 1'b1 || icache_rd_addr !== 32'h1C00_0000) begin fails++; $display("FAIL stall_rd%0d got %b %h want 1 1c000000", c, icache_rd_req, icache_rd_addr); end
         tests++; if (inst_sram_addr_ok !== 1'b0) begin fails++; $display("FAIL stall_addr_ok%0d got %b want 0", c, inst_sram_addr_ok); end
         step();
      end
      inst_sram_req = 1'b0;
      icache_ret_valid = 1'b0;
      icache_rd_rdy = 1'b1;
      step();
      icache_rd_rdy = 1'b0;
      icache_ret_valid = 1'b1;
      icache_ret_data = 32'h55;
      step();
      icache_ret_data = 32'h66;
      icache_ret_last = 1'b1;
      step();
      icache_ret_valid = 1'b0;
      icache_ret_last = 1'b0;
      #2;
      tests++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h55) begin fails++; $display("FAIL short_refill_w0 got ok=%b %h want ok=1 55", inst_sram_data_ok, inst_sram_rdata); end
      step();
      inst_sram_req = 1'b1;
      inst_sram_addr = 32'h1C00_000C;
      step();
      inst_sram_addr = 32'h1C00_0004;
      #2;
      tests++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'hA3) begin fails++; $display("FAIL short_refill_stale got ok=%b %h want ok=1 a3", inst_sram_data_ok, inst_sram_rdata); end
      step();
      inst_sram_req = 1'b0;
      #2;
      tests++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h66) begin fails++; $display("FAIL short_refill_w1 got ok=%b %h want ok=1 66", inst_sram_data_ok, inst_sram_rdata); end
      step();
   endtask

   task automatic test_reset_mid_refill;
      inst_sram_req = 1'b1;
      inst_sram_addr = 32'h1C00_0010;
      step();
      inst_sram_req = 1'b0;
      step();
      icache_rd_rdy = 1'b1;
      step();
      icache_rd_rdy = 1'b0;
      icache_ret_valid = 1'b1;
      icache_ret_data = 32'h77;
      step();
      icache_ret_data = 32'h88;
      step();
      icache_ret_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      #2;
      tests++; if (icache_rd_req !== 1'b0 || inst_sram_data_ok !== 1'b0 || icache_rd_addr !== 32'd0) begin fails++; $display("FAIL midreset_outs got %b %b %h want 0 0 0", icache_rd_req, inst_sram_data_ok, icache_rd_addr); end
      inst_sram_req = 1'b1;
      #2;
      tests++; if (inst_sram_addr_ok !== 1'b1) begin fails++; $display("FAIL midreset_idle got addr_ok %b want 1", inst_sram_addr_ok); end
      step();
      inst_sram_req = 1'b0;
      #2;
      tests++; if (inst_sram_data_ok !== 1'b0) begin fails++; $display("FAIL midreset_miss got data_ok %b want 0", inst_sram_data_ok); end
      step();
      #2;
      tests++; if (icache_rd_req !== 1'b1 || icache_rd_addr !== 32'h1C00_0010) begin fails++; $display("FAIL midreset_rd got %b %h want 1 1c000010", icache_rd_req, icache_rd_addr); end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_hit_stream();
      test_conflict_stall();
      test_reset_mid_refill();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 SHALL have parameter LINE_NUM, default 8, number of cache lines (power of two, 2..64); line size fixed at 16 bytes (4 words).
REQ-002 SHALL have ports clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports inst_sram_req  input  1  CPU fetch request; inst_sram_addr  input  32  fetch address (bits [1:0] ignored).
REQ-005 SHALL have ports inst_sram_addr_ok  output  1  request accepted; inst_sram_data_ok  output  1  instruction valid; inst_sram_rdata  output  32  instruction word.
REQ-006 SHALL have ports icache_rd_req  output  1; icache_rd_type  output  3; icache_rd_addr  output  32; icache_rd_rdy  input  1  refill address accepted.
REQ-007 SHALL have ports icache_ret_valid  input  1; icache_ret_last  input  1; icache_ret_data  input  32  refill beat.
REQ-008 SHALL, with ICACHE_PERF_CNT_EN defined, additionally have ports hit_cnt  output  32 and miss_cnt  output  32.

Function
REQ-009 SHALL decode address as tag = addr[31:4+log2(LINE_NUM)], index = addr[3+log2(LINE_NUM):4], word = addr[3:2].
REQ-010 SHALL store per line: valid bit, tag, four 32-bit words, in registers (no SRAM macro).
REQ-011 SHALL implement states IDLE, LOOKUP, MISS, REFILL, one-hot encoded.
REQ-012 SHALL assert inst_sram_addr_ok = inst_sram_req && (IDLE || (LOOKUP && hit)); on addr_ok, latch the address and enter/stay in LOOKUP.
REQ-013 SHALL in LOOKUP compute hit = valid[index] && tag match on the latched address, combinationally in the same cycle.
REQ-014 SHALL on LOOKUP hit assert inst_sram_data_ok for exactly that cycle with inst_sram_rdata = stored word; next state LOOKUP if a new request is accepted that cycle, else IDLE.
REQ-015 SHALL give hit latency exactly 1 cycle: data_ok the cycle after addr_ok; back-to-back hits sustain one fetch per cycle.
REQ-016 SHALL on LOOKUP miss deassert data_ok and addr_ok and enter MISS.
REQ-017 SHALL in MISS assert icache_rd_req=1, icache_rd_type=3'b100, icache_rd_addr={latched_addr[31:4],4'b0}, all held stable until icache_rd_rdy=1, then enter REFILL.
REQ-018 SHALL keep icache_rd_req=0 and icache_rd_addr/type stable (last value) in every other state.
REQ-019 SHALL in REFILL write each icache_ret_valid beat into word slot given by a 2-bit beat counter (reset to 0 on REFILL entry, increment per beat, wrap 3->0).
REQ-020 SHALL on the beat with icache_ret_last=1 set valid and tag of the line and return to LOOKUP, which then hits (miss latency: data_ok one cycle after the ret_last beat).
REQ-021 SHALL commit on ret_last regardless of beat count; missing words keep stale contents.
REQ-022 SHALL ignore icache_ret_valid in IDLE, LOOKUP, MISS.
REQ-023 SHALL never accept a CPU request in MISS or REFILL (addr_ok=0); refill of a line replaces the line at that index unconditionally (direct-mapped).

Reset
REQ-024 SHALL on reset clear all valid bits, state to IDLE, beat counter to 0, latched address to 0.
REQ-025 SHALL drive after reset: inst_sram_addr_ok=0 (unless req in IDLE), inst_sram_data_ok=0, inst_sram_rdata=0, icache_rd_req=0, icache_rd_type=3'b100, icache_rd_addr=0.
REQ-026 SHALL abandon any MISS/REFILL in progress when reset asserts mid-operation; no partial line becomes valid.

Configuration
REQ-027 SHALL with ICACHE_PERF_CNT_EN defined count LOOKUP hits in hit_cnt and LOOKUP misses in miss_cnt, each saturating at 32'hFFFF_FFFF, cleared by reset.
REQ-028 SHALL with ICACHE_PERF_CNT_EN undefined omit both ports and counters entirely; functional behaviour identical.

Verification
REQ-029 Cold miss: reset, req addr 0x1C00_0008 -> rd_req with rd_addr 0x1C00_0000, type 3'b100; beats 0x11,0x22,0x33,0x44 (last on 4th) -> data_ok with rdata 0x33 one cycle later.
REQ-030 Hit stream: after REQ-029, req 0x1C00_0000, 0x1C00_0004, 0x1C00_000C consecutive cycles -> addr_ok each cycle, data_ok rdata 0x11,0x22,0x44 on following cycles, no rd_req.
REQ-031 Conflict: LINE_NUM=8, req 0x1C00_0080 (same index 0, new tag) -> miss, refill, later 0x1C00_0000 misses again.
REQ-032 Stalled rd_rdy: hold rd_rdy=0 10 cycles -> rd_req/rd_addr stable all 10 cycles, addr_ok=0 throughout.
REQ-033 Reset mid-REFILL after 2 beats -> state IDLE, request to same address misses again.
REQ-034 With ICACHE_PERF_CNT_EN: REQ-029+REQ-030 sequence -> hit_cnt=4, miss_cnt=1.
